// File: rtl/tank_hit_detector.sv
// Tank/shell overlap hit detector: counts overlapping opaque pixels per frame and
// declares a hit after consecutive contact frames. Optional score counter: TANK_HIT_SCORE_EN.
module tank_hit_detector #(
    parameter int H_ACTIVE       = 1024,
    parameter int V_ACTIVE       = 768,
    parameter int OVERLAP_MIN    = 4,
    parameter int CONFIRM_FRAMES = 2,
    parameter int HOLDOFF_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [11:0] pixel_column,
    input  logic [11:0] pixel_row,
    input  logic [1:0]  tank_icon,
    input  logic [1:0]  shell_icon,
    input  logic        burst,
    input  logic        tank_reset,
    input  logic        score_clr,
    output logic        hit,
    output logic        shell_clear,
    output logic        armed,
    output logic [15:0] last_overlap,
    output logic [7:0]  hit_count
);

    localparam logic [11:0] H_ACT_C   = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT_C   = 12'(V_ACTIVE);
    localparam logic [15:0] OVL_MIN_C = 16'(OVERLAP_MIN);
    localparam logic [3:0]  CONFIRM_C = 4'(CONFIRM_FRAMES);
    localparam logic [7:0]  HOLDOFF_C = 8'(HOLDOFF_FRAMES);

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_LOCKOUT = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    state_t      state_r;
    logic [15:0] overlap_cnt_r;
    logic [15:0] last_overlap_r;
    logic [3:0]  confirm_cnt_r;
    logic [7:0]  holdoff_cnt_r;
    logic        hit_r;
    logic        shell_clear_r;
    logic        armed_r;

    logic in_active_s;
    logic overlap_px_s;
    logic fe_s;
    logic contact_s;

    assign in_active_s  = (pixel_column < H_ACT_C) && (pixel_row < V_ACT_C);
    assign overlap_px_s = pix_en && in_active_s && (tank_icon != 2'b00) && (shell_icon != 2'b00);
    // Frame end sits one row past the active area, so it can never coincide with a sample.
    assign fe_s         = pix_en && (pixel_row == V_ACT_C) && (pixel_column == 12'd0);
    assign contact_s    = (overlap_cnt_r >= OVL_MIN_C);

    // Per-frame overlap pixel counter, latched into last_overlap at frame end.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overlap_cnt_r  <= 16'd0;
            last_overlap_r <= 16'd0;
        end else if (fe_s) begin
            last_overlap_r <= overlap_cnt_r;
            overlap_cnt_r  <= 16'd0;
        end else if (overlap_px_s && (overlap_cnt_r != 16'hFFFF)) begin
            overlap_cnt_r  <= overlap_cnt_r + 16'd1;
        end
    end

    // Arm / lockout / hold-off state machine with registered strobes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_ARMED;
            confirm_cnt_r <= 4'd0;
            holdoff_cnt_r <= 8'd0;
            hit_r         <= 1'b0;
            shell_clear_r <= 1'b0;
            armed_r       <= 1'b1;
        end else begin
            hit_r         <= 1'b0;
            shell_clear_r <= 1'b0;
            case (state_r)
                ST_ARMED: begin
                    armed_r <= 1'b1;
                    if (fe_s) begin
                        if (contact_s) begin
                            if ((confirm_cnt_r + 4'd1) == CONFIRM_C) begin
                                hit_r         <= 1'b1;
                                shell_clear_r <= 1'b1;
                                confirm_cnt_r <= 4'd0;
                                armed_r       <= 1'b0;
                                state_r       <= ST_LOCKOUT;
                            end else begin
                                confirm_cnt_r <= confirm_cnt_r + 4'd1;
                            end
                        end else begin
                            confirm_cnt_r <= 4'd0;
                        end
                    end
                end
                ST_LOCKOUT: begin
                    armed_r <= 1'b0;
                    // A frame end on the same cycle as tank_reset is deliberately not counted.
                    if (tank_reset) begin
                        holdoff_cnt_r <= 8'd0;
                        if (HOLDOFF_FRAMES == 0) begin
                            confirm_cnt_r <= 4'd0;
                            armed_r       <= 1'b1;
                            state_r       <= ST_ARMED;
                        end else begin
                            state_r       <= ST_HOLDOFF;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    armed_r <= 1'b0;
                    if (fe_s) begin
                        holdoff_cnt_r <= holdoff_cnt_r + 8'd1;
                        if ((holdoff_cnt_r + 8'd1) == HOLDOFF_C) begin
                            confirm_cnt_r <= 4'd0;
                            armed_r       <= 1'b1;
                            state_r       <= ST_ARMED;
                        end
                    end
                end
                default: begin
                    confirm_cnt_r <= 4'd0;
                    holdoff_cnt_r <= 8'd0;
                    armed_r       <= 1'b1;
                    state_r       <= ST_ARMED;
                end
            endcase
        end
    end

    assign hit          = hit_r;
    assign shell_clear  = shell_clear_r;
    assign armed        = armed_r;
    assign last_overlap = last_overlap_r;

`ifdef TANK_HIT_SCORE_EN
    logic [7:0] hit_count_r;
    logic       unused_s;

    // Saturating hit score; a clear on the same cycle as a hit takes priority.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_count_r <= 8'd0;
        end else if (score_clr) begin
            hit_count_r <= 8'd0;
        end else if (hit_r && (hit_count_r != 8'hFF)) begin
            hit_count_r <= hit_count_r + 8'd1;
        end
    end

    assign hit_count = hit_count_r;
    assign unused_s  = burst;
`else
    logic unused_s;

    assign hit_count = 8'h00;
    assign unused_s  = burst ^ score_clr;
`endif

endmodule

// File: tb/tb_tank_hit_detector.sv
// Randomized self-checking bench for tank_hit_detector against a frame-level reference model.
module tb_tank_hit_detector;

    localparam int H    = 1024;
    localparam int V    = 768;
    localparam int OMIN = 4;
    localparam int CONF = 2;
    localparam int HOLD = 60;
`ifdef TANK_HIT_SCORE_EN
    localparam bit SCORE_EN = 1'b1;
`else
    localparam bit SCORE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pix_en = 1'b0;
    logic [11:0] pixel_column = 12'd0;
    logic [11:0] pixel_row = 12'd0;
    logic [1:0]  tank_icon = 2'd0;
    logic [1:0]  shell_icon = 2'd0;
    logic        burst = 1'b0;
    logic        tank_reset = 1'b0;
    logic        score_clr = 1'b0;
    logic        hit;
    logic        shell_clear;
    logic        armed;
    logic [15:0] last_overlap;
    logic [7:0]  hit_count;

    tank_hit_detector dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .pixel_column(pixel_column), .pixel_row(pixel_row),
        .tank_icon(tank_icon), .shell_icon(shell_icon), .burst(burst),
        .tank_reset(tank_reset), .score_clr(score_clr),
        .hit(hit), .shell_clear(shell_clear), .armed(armed),
        .last_overlap(last_overlap), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: mode 0 = armed, 1 = locked out, 2 = hold-off
    int m_mode;
    int m_streak;
    int m_left;
    int m_hits;
    int m_last;
    int frame_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pix_en = 1'b0; tank_icon = 2'd0; shell_icon = 2'd0;
        tank_reset = 1'b0; score_clr = 1'b0; burst = 1'($urandom_range(0, 1));
    endtask

    task automatic model_reset();
        m_mode = 0; m_streak = 0; m_left = 0; m_hits = 0; m_last = 0; frame_cnt = 0;
    endtask

    function automatic int exp_count();
        return SCORE_EN ? m_hits : 0;
    endfunction

    task automatic apply_reset(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            pix_en = 1'($urandom_range(0, 1));
            pixel_column = 12'($urandom_range(0, 1100));
            pixel_row = 12'($urandom_range(0, 800));
            tank_icon = 2'($urandom_range(0, 3));
            shell_icon = 2'($urandom_range(0, 3));
            tank_reset = 1'($urandom_range(0, 1));
            score_clr = 1'($urandom_range(0, 1));
            tick();
        end
        idle_inputs();
        reset = 1'b1;
        model_reset();
    endtask

    task automatic send_pixel(input int col, input int row, input int t, input int s, input bit en);
        pix_en = en; pixel_column = 12'(col); pixel_row = 12'(row);
        tank_icon = 2'(t); shell_icon = 2'(s);
        if (en && col < H && row < V && t != 0 && s != 0) frame_cnt++;
        tick();
    endtask

    task automatic send_overlap(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0)
                send_pixel(H - 1, V - 1, $urandom_range(1, 3), $urandom_range(1, 3), 1'b1);
            else
                send_pixel($urandom_range(0, H - 1), $urandom_range(0, V - 1),
                           $urandom_range(1, 3), $urandom_range(1, 3), 1'b1);
        end
    endtask

    // Pixels that must never count: disabled, out of range, or one icon transparent.
    task automatic send_noise(input int n);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 4))
                0: send_pixel($urandom_range(0, H - 1), $urandom_range(0, V - 1), 3, 3, 1'b0);
                1: send_pixel(H, $urandom_range(0, V - 1), 1, 2, 1'b1);
                2: send_pixel($urandom_range(1, H - 1), V, 2, 1, 1'b1);
                3: send_pixel($urandom_range(0, H - 1), $urandom_range(0, V - 1), 0, $urandom_range(1, 3), 1'b1);
                default: send_pixel($urandom_range(0, H - 1), $urandom_range(0, V - 1), $urandom_range(1, 3), 0, 1'b1);
            endcase
        end
    endtask

    task automatic send_random(input int n);
        int c;
        int r;
        for (int i = 0; i < n; i++) begin
            c = $urandom_range(0, 1100);
            r = $urandom_range(0, 800);
            if (r == V && c == 0) c = 1;
            send_pixel(c, r, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic model_fe(input bit tr, output bit exp_hit);
        exp_hit = 1'b0;
        m_last = (frame_cnt > 65535) ? 65535 : frame_cnt;
        frame_cnt = 0;
        if (tr && m_mode == 1) begin
            m_mode = (HOLD == 0) ? 0 : 2;
            m_left = HOLD;
            m_streak = 0;
        end else if (m_mode == 0) begin
            if (m_last >= OMIN) begin
                m_streak++;
                if (m_streak == CONF) begin
                    exp_hit = 1'b1; m_streak = 0; m_mode = 1;
                end
            end else begin
                m_streak = 0;
            end
        end else if (m_mode == 2) begin
            m_left--;
            if (m_left == 0) m_mode = 0;
        end
    endtask

    task automatic end_frame(input bit tr, input bit clr);
        bit eh;
        model_fe(tr, eh);
        pix_en = 1'b1; pixel_row = 12'(V); pixel_column = 12'd0;
        tank_icon = 2'($urandom_range(0, 3)); shell_icon = 2'($urandom_range(0, 3));
        tank_reset = tr;
        tick();
        tests_run++;
        if (last_overlap !== 16'(m_last)) begin
            tests_failed++; $display("FAIL last_overlap got %0d expected %0d", last_overlap, m_last);
        end
        tests_run++;
        if (hit !== eh || shell_clear !== eh) begin
            tests_failed++; $display("FAIL hit_strobe got hit=%0b shell_clear=%0b expected %0b", hit, shell_clear, eh);
        end
        tests_run++;
        if (armed !== (m_mode == 0)) begin
            tests_failed++; $display("FAIL armed_fe got %0b expected %0b", armed, (m_mode == 0));
        end
        idle_inputs();
        score_clr = clr;
        if (clr) m_hits = 0;
        else if (eh && m_hits < 255) m_hits++;
        tick();
        score_clr = 1'b0;
        tests_run++;
        if (hit !== 1'b0 || shell_clear !== 1'b0) begin
            tests_failed++; $display("FAIL strobe_width got hit=%0b shell_clear=%0b expected 0", hit, shell_clear);
        end
        tests_run++;
        if (hit_count !== 8'(exp_count())) begin
            tests_failed++; $display("FAIL hit_count got %0d expected %0d", hit_count, exp_count());
        end
    endtask

    task automatic pulse_tank_reset();
        tank_reset = 1'b1; pix_en = 1'b0;
        if (m_mode == 1) begin
            m_mode = (HOLD == 0) ? 0 : 2; m_left = HOLD; m_streak = 0;
        end
        tick();
        tank_reset = 1'b0;
        tick();
        tests_run++;
        if (armed !== (m_mode == 0)) begin
            tests_failed++; $display("FAIL armed_tank_reset got %0b expected %0b", armed, (m_mode == 0));
        end
    endtask

    task automatic check_reset_values(input string tag);
        tests_run++;
        if (hit !== 1'b0 || shell_clear !== 1'b0 || armed !== 1'b1 ||
            last_overlap !== 16'd0 || hit_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL %s got hit=%0b sc=%0b armed=%0b last=%0d cnt=%0d expected 0 0 1 0 0",
                     tag, hit, shell_clear, armed, last_overlap, hit_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pix_en = 1'($urandom_range(0, 1)); tank_reset = 1'($urandom_range(0, 1));
            tank_icon = 2'($urandom_range(0, 3)); shell_icon = 2'($urandom_range(0, 3));
            tick();
        end
        check_reset_values("reset_initial");
        apply_reset(2);
        send_overlap(7);
        end_frame(1'b0, 1'b0);
        apply_reset(3);
        check_reset_values("reset_after_frame");
    endtask

    task automatic test_two_frame_hit();
        apply_reset(2);
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 10; r++)
                for (int c = 0; c < 10; c++)
                    send_pixel(300 + c, 400 + r, $urandom_range(1, 3), $urandom_range(1, 3), 1'b1);
            send_noise(12);
            end_frame(1'b0, 1'b0);
        end
    endtask

    task automatic test_non_consecutive();
        int pat[4] = '{3, 50, 0, 50};
        apply_reset(2);
        for (int f = 0; f < 4; f++) begin
            send_overlap(pat[f]);
            send_noise(5);
            end_frame(1'b0, 1'b0);
        end
    endtask

    task automatic test_lockout_holdoff();
        apply_reset(2);
        for (int f = 0; f < 2; f++) begin send_overlap(6); end_frame(1'b0, 1'b0); end
        for (int f = 0; f < 100; f++) begin send_overlap(5); end_frame(1'b0, 1'b0); end
        pulse_tank_reset();
        for (int f = 0; f < HOLD; f++) begin
            send_overlap(5);
            if (f == 30) pulse_tank_reset();
            end_frame(1'b0, 1'b0);
        end
        for (int f = 0; f < 2; f++) begin send_overlap(8); end_frame(1'b0, 1'b0); end
    endtask

    task automatic test_coincident_reset();
        apply_reset(2);
        for (int f = 0; f < 2; f++) begin send_overlap(4); end_frame(1'b0, 1'b0); end
        send_overlap(5);
        end_frame(1'b1, 1'b0);
        for (int f = 0; f < HOLD; f++) begin send_overlap(1); end_frame(1'b0, 1'b0); end
        send_overlap(4);
        end_frame(1'b0, 1'b0);
        send_overlap(4);
        end_frame(1'b0, 1'b1);
    endtask

    task automatic test_reset_during_hit();
        apply_reset(2);
        send_overlap(5); end_frame(1'b0, 1'b0);
        send_overlap(5);
        pix_en = 1'b1; pixel_row = 12'(V); pixel_column = 12'd0;
        tick();
        tests_run++;
        if (hit !== 1'b1) begin
            tests_failed++; $display("FAIL pre_reset_hit got %0b expected 1", hit);
        end
        idle_inputs();
        reset = 1'b0;
        tick();
        check_reset_values("reset_during_hit");
        reset = 1'b1;
        model_reset();
        tick();
        check_reset_values("after_reset_release");
    endtask

    task automatic test_random();
        apply_reset(2);
        for (int f = 0; f < 40; f++) begin
            send_overlap($urandom_range(0, 6));
            send_noise($urandom_range(0, 4));
            send_random($urandom_range(0, 10));
            if ($urandom_range(0, 4) == 0) pulse_tank_reset();
            end_frame(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_two_frame_hit();
        test_non_consecutive();
        test_lockout_holdoff();
        test_coincident_reset();
        test_reset_during_hit();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
